// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit for the EX stage. It owns the architectural
// HI/LO registers. MULT/MULTU use a shift-add loop and DIV/DIVU use a
// restoring shift-subtract loop. Both loops run on operand magnitudes, and
// the signs are applied in a final FIX cycle.
//
// Ports:
//   clock_i       system clock, all state updates on posedge
//   reset_i       synchronous active-high reset, aborts any operation
//   start_i       launch op_i on a_i/b_i (accepted only while idle)
//   op_i          00=MULT 01=MULTU 10=DIV 11=DIVU
//   a_i, b_i      rs / rt operands
//   hilo_we_i     MTHI/MTLO strobe (idle only, start_i wins)
//   hilo_sel_i    0=LO 1=HI, target of hilo_we_i and source of rdata_o
//   hilo_wdata_i  MTHI/MTLO data
//   rdata_o       combinational MFHI/MFLO read
//   hi_o, lo_o    HI/LO registers
//   busy_o        high whenever the unit is not idle
//   done_o        one-cycle pulse when HI/LO first show a new result
//
// Optional feature, enabled by defining the macro MULDIV_FAST_MUL_EN:
//   MULT/MULTU use a single-cycle array multiplier and skip the iterative
//   loop. The result is visible two edges after start. DIV/DIVU do not change.
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            hilo_we_i,
  input  logic            hilo_sel_i,
  input  logic [XLEN-1:0] hilo_wdata_i,
  output logic [XLEN-1:0] rdata_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic            busy_o,
  output logic            done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
`ifdef MULDIV_FAST_MUL_EN
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`endif

  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
    return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v);
    return (~v) + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  state_e              state_q, state_d;
  logic                is_div_q, is_div_d;
  logic                neg_q, neg_d;     // negate product / quotient
  logic                rneg_q, rneg_d;   // negate remainder (sign of dividend)
  logic [XLEN-1:0]     opnd_q, opnd_d;   // |multiplicand| or |divisor|
  logic [2*XLEN-1:0]   acc_q, acc_d;     // mul: {partial, multiplier}; div: {rem, dividend/quotient}
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;
  logic                done_q, done_d;

  logic                a_neg_s, b_neg_s;
  logic [XLEN-1:0]     mag_a_s, mag_b_s;
  logic [XLEN:0]       mul_sum_s;
  logic                div_ge_s;
  logic [XLEN-1:0]     div_diff_s;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     quo_s, rem_s, fix_hi_s, fix_lo_s;

  // Only the signed ops (op_i[0]==0) treat the operand MSB as a sign bit.
  assign a_neg_s = ~op_i[0] & a_i[XLEN-1];
  assign b_neg_s = ~op_i[0] & b_i[XLEN-1];
  assign mag_a_s = a_neg_s ? neg_w(a_i) : a_i;
  assign mag_b_s = b_neg_s ? neg_w(b_i) : b_i;

  // One shift-add step. The carry out of the upper half shifts back in at the MSB.
  assign mul_sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]}
                   + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};

  // One restoring step. The trial value is {remainder, next dividend bit}.
  // It can be XLEN+1 bits wide, so the compare uses all of it. The difference
  // is smaller than the divisor, so its low XLEN bits are enough.
  assign div_ge_s   = acc_q[2*XLEN-1:XLEN-1] >= {1'b0, opnd_q};
  assign div_diff_s = acc_q[2*XLEN-2:XLEN-1] - opnd_q;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod_s;
  assign fast_prod_s = {{XLEN{1'b0}}, opnd_q} * {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
`endif

  // Sign fixup of the finished magnitudes.
  assign prod_s   = neg_q  ? neg_dw(acc_q) : acc_q;
  assign quo_s    = neg_q  ? neg_w(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
  assign rem_s    = rneg_q ? neg_w(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
  assign fix_hi_s = is_div_q ? rem_s : prod_s[2*XLEN-1:XLEN];
  assign fix_lo_s = is_div_q ? quo_s : prod_s[XLEN-1:0];

  // Next-state and datapath logic for the IDLE -> RUN -> FIX sequence.
  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          is_div_d = op_i[1];
          opnd_d   = op_i[1] ? mag_b_s : mag_a_s;
          acc_d    = {{XLEN{1'b0}}, (op_i[1] ? mag_a_s : mag_b_s)};
          cnt_d    = {CNT_W{1'b0}};
          if (op_i[1]) begin
            // Divide by zero keeps the all-ones quotient unsigned. The
            // remainder then rebuilds a_i from |a| and the sign of a.
            neg_d  = (a_neg_s ^ b_neg_s) & (|b_i);
            rneg_d = a_neg_s;
          end else begin
            neg_d  = a_neg_s ^ b_neg_s;
            rneg_d = 1'b0;
          end
`ifdef MULDIV_FAST_MUL_EN
          state_d = op_i[1] ? S_RUN : S_FIX;
`else
          state_d = S_RUN;
`endif
        end else if (hilo_we_i) begin
          if (hilo_sel_i) begin
            hi_d = hilo_wdata_i;
          end else begin
            lo_d = hilo_wdata_i;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (is_div_q) begin
          if (div_ge_s) begin
            acc_d = {div_diff_s, acc_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = {acc_q[2*XLEN-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum_s, acc_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIX: begin
`ifdef MULDIV_FAST_MUL_EN
        // The first FIX cycle of a fast multiply loads the product.
        if (!is_div_q && (cnt_q == {CNT_W{1'b0}})) begin
          acc_d = fast_prod_s;
          cnt_d = CNT_ONE;
        end else begin
          hi_d    = fix_hi_s;
          lo_d    = fix_lo_s;
          done_d  = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_IDLE;
        end
`else
        hi_d    = fix_hi_s;
        lo_d    = fix_lo_s;
        done_d  = 1'b1;
        cnt_d   = {CNT_W{1'b0}};
        state_d = S_IDLE;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers, with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      opnd_q   <= {XLEN{1'b0}};
      acc_q    <= {(2*XLEN){1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      hi_q     <= {XLEN{1'b0}};
      lo_q     <= {XLEN{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q != S_IDLE);
  assign rdata_o = hilo_sel_i ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Directed and randomized bench for muldiv_unit. A reference model computes
// expected HI/LO with plain 64-bit arithmetic. It checks reset, latency,
// busy/done timing, MTHI/MTLO, ignored requests while busy, abort by reset,
// back-to-back starts and the divide corner cases.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset, start, hilo_we, hilo_sel;
  logic [1:0]  op;
  logic [31:0] a, b, hilo_wdata;
  logic [31:0] rdata, hi, lo;
  logic        busy, done;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_hi = 32'h0;
  logic [31:0] exp_lo = 32'h0;

  always #5 clock = ~clock;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .start_i     (start),
    .op_i        (op),
    .a_i         (a),
    .b_i         (b),
    .hilo_we_i   (hilo_we),
    .hilo_sel_i  (hilo_sel),
    .hilo_wdata_i(hilo_wdata),
    .rdata_o     (rdata),
    .hi_o        (hi),
    .lo_o        (lo),
    .busy_o      (busy),
    .done_o      (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural result, computed with wide signed/unsigned arithmetic.
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] rh, output logic [31:0] rl);
    longint          sx, sy, sp, sq, sr;
    longint unsigned ux, uy, up;
    sx = $signed(x);
    sy = $signed(y);
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (o)
      2'b00: begin sp = sx * sy; rh = sp[63:32]; rl = sp[31:0]; end
      2'b01: begin up = ux * uy; rh = up[63:32]; rl = up[31:0]; end
      2'b10: begin
        if (y == 32'h0) begin rh = x; rl = 32'hFFFFFFFF; end
        else begin sq = sx / sy; sr = sx % sy; rh = sr[31:0]; rl = sq[31:0]; end
      end
      default: begin
        if (y == 32'h0) begin rh = x; rl = 32'hFFFFFFFF; end
        else begin rh = x % y; rl = x / y; end
      end
    endcase
  endfunction

  // Launch at the next edge. inj>0 pulses a DIVU start plus an MTHI at edge E(inj).
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int inj);
    logic [31:0] mh, ml;
    int lat;
    ref_model(o, x, y, mh, ml);
    lat = 33;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[1]) lat = 2;
`endif
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    check("busy_after_start", {31'h0, busy}, 32'h1);
    check("done_low_after_start", {31'h0, done}, 32'h0);
    for (int k = 1; k < lat; k++) begin
      if (k == inj) begin
        start = 1'b1; op = 2'b11; hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'hDEADBEEF;
      end
      @(posedge clock); #1;
      start = 1'b0; hilo_we = 1'b0;
      check("busy_running", {31'h0, busy}, 32'h1);
      check("done_running", {31'h0, done}, 32'h0);
      check("hi_held", hi, exp_hi);
      check("lo_held", lo, exp_lo);
    end
    @(posedge clock); #1;
    exp_hi = mh;
    exp_lo = ml;
    check("done_pulse", {31'h0, done}, 32'h1);
    check("busy_idle", {31'h0, busy}, 32'h0);
    check("hi_result", hi, exp_hi);
    check("lo_result", lo, exp_lo);
    check("rdata_result", rdata, hilo_sel ? exp_hi : exp_lo);
  endtask

  task automatic done_drops;
    @(posedge clock); #1;
    check("done_one_cycle", {31'h0, done}, 32'h0);
  endtask

  initial begin
    logic        seen_done;
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    reset = 1'b1; start = 1'b0; hilo_we = 1'b0; hilo_sel = 1'b0;
    op = 2'b00; a = 32'h0; b = 32'h0; hilo_wdata = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    reset = 1'b0;

    // Test-plan vectors.
    run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 0); done_drops();
    check("mult_neg_hi", hi, 32'hFFFFFFFF);
    check("mult_neg_lo", lo, 32'hFFFFFFEB);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0); done_drops();
    check("multu_max_hi", hi, 32'hFFFFFFFE);
    check("multu_max_lo", lo, 32'h00000001);
    run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 0); done_drops();
    check("div_neg_lo", lo, 32'hFFFFFFFD);
    check("div_neg_hi", hi, 32'hFFFFFFFF);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0); done_drops();
    check("div_ovf_lo", lo, 32'h80000000);
    check("div_ovf_hi", hi, 32'h00000000);
    run_op(2'b10, 32'hFFFFFF00, 32'h00000000, 0); done_drops();
    check("div_zero_neg_lo", lo, 32'hFFFFFFFF);
    check("div_zero_neg_hi", hi, 32'hFFFFFF00);
    run_op(2'b11, 32'h12345678, 32'h00000000, 0); done_drops();
    check("divu_zero_lo", lo, 32'hFFFFFFFF);
    check("divu_zero_hi", hi, 32'h12345678);

    // MTHI / MTLO while idle.
    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'hDEADBEEF;
    @(posedge clock); #1;
    hilo_we = 1'b0; exp_hi = 32'hDEADBEEF;
    check("mthi_hi", hi, exp_hi);
    check("mfhi_rdata", rdata, 32'hDEADBEEF);
    hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'h0BADF00D;
    @(posedge clock); #1;
    hilo_we = 1'b0; exp_lo = 32'h0BADF00D;
    check("mtlo_lo", lo, exp_lo);
    check("mtlo_hi_kept", hi, exp_hi);
    check("mflo_rdata", rdata, 32'h0BADF00D);

    // A start plus an MTHI issued while busy must both be dropped.
    run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 10); done_drops();
    check("ignored_hi", hi, 32'hFFFFFFFF);
    check("ignored_lo", lo, 32'hFFFFFFEB);
    check("ignored_busy", {31'h0, busy}, 32'h0);

    // Reset in the middle of a DIV aborts it with no result.
    start = 1'b1; op = 2'b10; a = 32'hFFFFFFF9; b = 32'h00000002;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; exp_hi = 32'h0; exp_lo = 32'h0;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) seen_done = 1'b1;
    end
    check("abort_no_done", {31'h0, seen_done}, 32'h0);
    check("abort_hi_late", hi, 32'h0);
    check("abort_lo_late", lo, 32'h0);

    // Random ops. Odd iterations chain straight into the next start.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      if (i % 8 == 0) ry = 32'h0;
      if (i % 8 == 1) ry = 32'($urandom_range(1, 15));
      if (i % 8 == 2) rx = 32'h80000000;
      hilo_sel = 1'($urandom_range(0, 1));
      run_op(ro, rx, ry, 0);
      if (i % 2 == 0) done_drops();
    end
    done_drops();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the register file.
- Consumes the rs/rt read values for MULT/MULTU/DIV/DIVU.
- Owns the architectural HI/LO registers; MFHI/MFLO data returns to the register-file write path.
- Multi-cycle. The core stalls any MULT/DIV/MFHI/MFLO/MTHI/MTLO while busy=1.

Parameters:
- XLEN, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch an operation; sampled on posedge, only when busy=0.
- op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
- a  input  XLEN  operand from rs (multiplicand / dividend).
- b  input  XLEN  operand from rt (multiplier / divisor).
- hilo_we  input  1  MTHI/MTLO write strobe.
- hilo_sel  input  1  0=LO, 1=HI; selects the target of hilo_we and the source of rdata.
- hilo_wdata  input  XLEN  MTHI/MTLO data.
- rdata  output  XLEN  combinational: hilo_sel ? HI : LO (MFHI/MFLO).
- hi  output  XLEN  HI register.
- lo  output  XLEN  LO register.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse, high in the cycle HI/LO first show a new result.

Behaviour:
- Reset: state=IDLE, HI=0, LO=0, busy=0, done=0, counter=0. Reset at any time aborts an operation in progress with no HI/LO update.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE, start=1:
  - Latch op, |a| and |b| (absolute values for signed ops), result sign, remainder sign; counter=0; go to RUN.
  - start has priority over hilo_we in the same cycle; that hilo_we is dropped.
- IDLE, start=0, hilo_we=1: write hilo_wdata to HI or LO on that edge.
- RUN: one iteration per cycle for XLEN cycles (counter 0..XLEN-1), then go to FIX.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract, producing quotient and remainder.
- FIX, apply sign fixup and write results:
  - Multiply: {HI,LO} = 64-bit product, negated if the result sign is negative (MULT only).
  - Divide: LO = quotient, negated if sign(a) != sign(b) (DIV only); HI = remainder, taking the sign of a.
  - Go to IDLE; done=1 in the following cycle.
- Latency: start edge E0, HI/LO/done visible after edge E(XLEN+1) = E33. busy is high in the cycles after E0 through E32.
- While busy=1: start and hilo_we are ignored. rdata, hi and lo show the old values.
- Divide by zero (b=0), DIV or DIVU: LO=all-ones, HI=a unmodified, no sign fixup; same latency.
- DIV overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. Falls out naturally from unsigned magnitudes; no special case is required.
- MULTU/DIVU: operands are treated as unsigned and no fixup is applied.
- Back-to-back: start may be asserted in the same cycle done=1 (state is IDLE).

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU compute the full product with a single-cycle array multiplier.
  - State goes IDLE -> FIX directly; HI/LO/done are visible after E2.
  - DIV/DIVU are unchanged.
- Undefined: all operations take the iterative 33-cycle path above; no hardware multiplier is inferred.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> after E33: HI=0xFFFFFFFF, LO=0xFFFFFFEB, done pulses for exactly 1 cycle, busy=1 through E32.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. With MULDIV_FAST_MUL_EN, same values visible after E2.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678, done after E33.
- Start a MULT, then at E10 pulse start (DIVU) and hilo_we (HI, 0xDEADBEEF) -> both ignored; the MULT result lands at E33. In IDLE, hilo_we HI=0xDEADBEEF, then hilo_sel=1 -> rdata=0xDEADBEEF.
- Start DIV, assert reset at E15 -> busy=0, done=0, HI=LO=0 after E15; no result is ever written.
